apb_master: RTL and testbench

- APB requester (initiator) for the on-chip APB bus, one slave select.
- Converts a simple valid/ready command interface (address, write flag, write data) into compliant APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response interface.
- Used to drive the UART register block from a local controller and to act as the bus-side driver in block-level benches.

---
 rtl/apb_master.sv | 130 +++++++++++++
 tb/tb_apb_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB SETUP/ACCESS transfer
// and returns read data / error on a valid/ready response. Optional APB_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR,
  output logic [1:0]            o_dbg_state
);

  // Handshakes: a command transfers on the rising edge where cmd_valid && cmd_ready,
  // a response on the edge where rsp_valid && rsp_ready; valid never waits on ready.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_timeout;
  logic                  r_cmd_ready;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;

  // Abort on the edge that closes the TIMEOUT_CYCLES-th consecutive wait cycle.
  assign w_timeout = (r_state == ST_ACCESS) && !PREADY &&
                     (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_ACCESS) begin
      r_to_cnt <= '0;
    end else if (!PREADY) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  // Without the counter the limit has no effect; this folds to constant 0.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (cmd_valid) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (PREADY || w_timeout) w_next = ST_RESP;
      ST_RESP:   if (rsp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= (w_next == ST_IDLE);
      r_psel      <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
      r_penable   <= (w_next == ST_ACCESS);
      r_rsp_valid <= (w_next == ST_RESP);
      if (r_state == ST_IDLE && cmd_valid) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_wdata;
      end
      // Slave response is only meaningful in ACCESS with PREADY high.
      if (r_state == ST_ACCESS && PREADY) begin
        r_err   <= PSLVERR;
        r_rdata <= r_pwrite ? '0 : PRDATA;
      end else if (w_timeout) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign PSELx       = r_psel;
  assign PENABLE     = r_penable;
  assign rsp_valid   = r_rsp_valid;
  assign PADDR       = r_paddr;
  assign PWRITE      = r_pwrite;
  assign PWDATA      = r_pwdata;
  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: scheduled random transfers, per-cycle expected-output queue,
// directed cases for write, wait-state read, slave error, backpressure, reset and timeout.
module tb_apb_master;

  localparam int AW = 4;
  localparam int DW = 8;
`ifdef APB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif
  localparam int EW = 4 + DW + 1 + AW + 1 + DW;

  logic          PCLK;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;
  logic [1:0]    dbg_state;

  apb_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PADDR(PADDR),
    .PSELx(PSELx),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .PREADY(PREADY),
    .PRDATA(PRDATA),
    .PSLVERR(PSLVERR),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  logic [EW-1:0] exp_q[$];

  // Model of the architecturally visible held values.
  logic [AW-1:0] m_addr;
  logic          m_write;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit cr, input bit ps, input bit pe, input bit rv);
    exp_q.push_back({cr, ps, pe, rv, m_rdata, m_err, m_addr, m_write, m_wdata});
  endtask

  logic          e_cr, e_ps, e_pe, e_rv, e_err, e_wr;
  logic [DW-1:0] e_rdata, e_wdata;
  logic [AW-1:0] e_addr;

  always @(negedge PCLK) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL exp_queue: empty at %0t", $time);
      end else begin
        {e_cr, e_ps, e_pe, e_rv, e_rdata, e_err, e_addr, e_wr, e_wdata} = exp_q.pop_front();
        check("cmd_ready", 32'(cmd_ready), 32'(e_cr));
        check("PSELx",     32'(PSELx),     32'(e_ps));
        check("PENABLE",   32'(PENABLE),   32'(e_pe));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check("PADDR",     32'(PADDR),     32'(e_addr));
        check("PWRITE",    32'(PWRITE),    32'(e_wr));
        check("PWDATA",    32'(PWDATA),    32'(e_wdata));
        check("dbg_state_known", 32'($isunknown(dbg_state)), 32'(0));
        if (e_rv) begin
          check("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
          check("rsp_err",   32'(rsp_err),   32'(e_err));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic junk_bus();
    PREADY  = 1'($urandom_range(0, 1));
    PRDATA  = DW'($urandom);
    PSLVERR = 1'($urandom_range(0, 1));
  endtask

  task automatic busy_cmd(input bit hold);
    cmd_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
  endtask

  task automatic model_reset();
    m_addr  = '0;
    m_write = 1'b0;
    m_wdata = '0;
    m_rdata = '0;
    m_err   = 1'b0;
  endtask

  // One full transfer; returns during the response handshake cycle.
  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int w, input bit er, input logic [DW-1:0] rd,
                         input int s, input int idle, input bit hold);
    int  n_acc;
    bit  aborted;
    repeat (idle) begin
      tick();
      busy_cmd(1'b0);
      cmd_valid = 1'b0;
      junk_bus();
      rsp_ready = 1'($urandom_range(0, 1));
      push_exp(1, 0, 0, 0);
    end
    tick();
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    junk_bus();
    rsp_ready = 1'($urandom_range(0, 1));
    push_exp(1, 0, 0, 0);
    m_addr  = a;
    m_write = wr;
    m_wdata = wd;
    tick();
    busy_cmd(hold);
    junk_bus();
    rsp_ready = 1'($urandom_range(0, 1));
    push_exp(0, 1, 0, 0);
    n_acc   = w + 1;
    aborted = 1'b0;
`ifdef APB_TIMEOUT_EN
    if (w >= TO) begin
      n_acc   = TO;
      aborted = 1'b1;
    end
`endif
    for (int i = 0; i < n_acc; i++) begin
      tick();
      busy_cmd(hold);
      rsp_ready = 1'($urandom_range(0, 1));
      PREADY    = !aborted && (i == w);
      PRDATA    = PREADY ? rd : DW'($urandom);
      PSLVERR   = PREADY ? er : 1'($urandom_range(0, 1));
      push_exp(0, 1, 1, 0);
    end
    m_rdata = (aborted || wr) ? '0 : rd;
    m_err   = aborted ? 1'b1 : er;
    for (int j = 0; j <= s; j++) begin
      tick();
      busy_cmd(hold);
      junk_bus();
      rsp_ready = (j == s);
      push_exp(0, 0, 0, 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;
    model_reset();
    #12;
    check("reset_cmd_ready", 32'(cmd_ready), 32'(1));
    check("reset_PSELx",     32'(PSELx),     32'(0));
    check("reset_PENABLE",   32'(PENABLE),   32'(0));
    check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    check("reset_PADDR",     32'(PADDR),     32'(0));
    check("reset_PWDATA",    32'(PWDATA),    32'(0));
    tick();
    PRESETn = 1'b1;
    chk_en  = 1'b1;
    push_exp(1, 0, 0, 0);

    // Zero-wait write; slave drives nonzero PRDATA that must not appear.
    run_txn(1'b1, 4'h3, 8'hA5, 0, 1'b0, 8'h77, 0, 0, 1'b0);
    check("wr_PADDR",     32'(PADDR),     32'h3);
    check("wr_PWDATA",    32'(PWDATA),    32'hA5);
    check("wr_PWRITE",    32'(PWRITE),    32'h1);
    check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check("wr_rsp_err",   32'(rsp_err),   32'h0);
    check("wr_rsp_rdata", 32'(rsp_rdata), 32'h00);

    // Read with three wait states.
    run_txn(1'b0, 4'h1, 8'h00, 3, 1'b0, 8'h5C, 0, 1, 1'b0);
    check("rd3_rsp_rdata", 32'(rsp_rdata), 32'h5C);
    check("rd3_PWRITE",    32'(PWRITE),    32'h0);

    // Slave error, then a clean transfer.
    run_txn(1'b1, 4'hF, 8'h11, 0, 1'b1, 8'h00, 0, 0, 1'b0);
    check("err_rsp_err", 32'(rsp_err), 32'h1);
    run_txn(1'b1, 4'hE, 8'h22, 1, 1'b0, 8'h00, 0, 0, 1'b0);
    check("noerr_rsp_err", 32'(rsp_err), 32'h0);

    // Response backpressure with cmd_valid held high.
    run_txn(1'b0, 4'h2, 8'h00, 1, 1'b0, 8'h3C, 5, 0, 1'b1);
    check("bp_rsp_rdata", 32'(rsp_rdata), 32'h3C);
    check("bp_cmd_ready", 32'(cmd_ready), 32'h0);

    // Reset during an ACCESS wait state.
    tick();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'h6;
    junk_bus();
    push_exp(1, 0, 0, 0);
    m_addr  = 4'h6;
    m_write = 1'b0;
    m_wdata = cmd_wdata;
    tick();
    busy_cmd(1'b1);
    PREADY = 1'b0;
    push_exp(0, 1, 0, 0);
    repeat (2) begin
      tick();
      busy_cmd(1'b1);
      PREADY = 1'b0;
      push_exp(0, 1, 1, 0);
    end
    @(negedge PCLK);
    #1;
    chk_en  = 1'b0;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_PSELx",     32'(PSELx),     32'(0));
    check("rst_mid_PENABLE",   32'(PENABLE),   32'(0));
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b0;
    repeat (2) tick();
    PRESETn = 1'b1;
    model_reset();
    exp_q.delete();
    chk_en = 1'b1;
    push_exp(1, 0, 0, 0);
    repeat (3) begin
      tick();
      cmd_valid = 1'b0;
      junk_bus();
      rsp_ready = 1'b1;
      push_exp(1, 0, 0, 0);
    end
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));

`ifdef APB_TIMEOUT_EN
    // Slave never ready: abort after TO wait cycles; PREADY on the last allowed cycle wins.
    run_txn(1'b0, 4'h9, 8'h00, TO + 20, 1'b0, 8'hAB, 0, 0, 1'b0);
    check("to_rsp_err",   32'(rsp_err),   32'h1);
    check("to_rsp_rdata", 32'(rsp_rdata), 32'h0);
    run_txn(1'b0, 4'h9, 8'h00, TO - 1, 1'b0, 8'hAB, 0, 0, 1'b0);
    check("to_edge_rsp_err",   32'(rsp_err),   32'h0);
    check("to_edge_rsp_rdata", 32'(rsp_rdata), 32'hAB);
`else
    // Long stall: PSELx/PENABLE must stay high for every one of the wait cycles.
    run_txn(1'b0, 4'h9, 8'h00, 110, 1'b0, 8'hAB, 0, 0, 1'b0);
    check("long_rsp_rdata", 32'(rsp_rdata), 32'hAB);
`endif

    // Randomized transfers.
    for (int k = 0; k < 150; k++) begin
`ifdef APB_TIMEOUT_EN
      run_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
              $urandom_range(0, TO + 2), 1'($urandom_range(0, 1)), DW'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
`else
      run_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
              $urandom_range(0, 5), 1'($urandom_range(0, 1)), DW'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
`endif
    end

    tick();
    cmd_valid = 1'b0;
    push_exp(1, 0, 0, 0);
    @(negedge PCLK);
    #1;
    chk_en = 1'b0;
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
